// File: rtl/ofmap_buf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// ofmap_buf_ctrl_pkg : shared defaults and read-credit helper for ofmap buffer
// Rev 1.0
// ============================================================================
package ofmap_buf_ctrl_pkg;

   localparam int SRAM_NUM_DEF = 4;
   localparam int ADDR_W_DEF = 7;
   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 128;
   localparam int FIFO_DEPTH = 2;

   // A new read may be issued only if every beat already owed to the FIFO,
   // plus this one, still fits after the pop happening this cycle.
   function automatic logic rd_credit_ok(input logic [1:0] occ,
                                         input logic       pend_a,
                                         input logic       pend_b,
                                         input logic       pop);
      logic [2:0] used;
      used = {1'b0, occ} + {2'b00, pend_a} + {2'b00, pend_b};
      return (used - {2'b00, pop}) < 3'(FIFO_DEPTH);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ofmap_out_fifo.sv
`default_nettype none
// ============================================================================
// ofmap_out_fifo : 2-entry synchronous FIFO with push/pop and occupancy
// Rev 1.0
// ============================================================================
module ofmap_out_fifo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       occ,
   output logic             empty
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_idx;
   logic             r_rd_idx;
   logic [1:0]       r_occ;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = pop & (r_occ != 2'd0);
   assign w_push = push & ((r_occ != 2'd2) | w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) r_mem[i] <= '0;
         r_wr_idx <= 1'b0;
         r_rd_idx <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_idx] <= push_data;
            r_wr_idx        <= ~r_wr_idx;
         end
         if (w_pop) r_rd_idx <= ~r_rd_idx;
         r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign head  = r_mem[r_rd_idx];
   assign occ   = r_occ;
   assign empty = (r_occ == 2'd0);

endmodule
`default_nettype wire

// File: rtl/ofmap_buf_ctrl.sv
`default_nettype none
// ============================================================================
// ofmap_buf_ctrl : writes one frame of PE results into the ofmap SRAM banks,
//                  then streams it back out in order.          Rev 1.0
// ============================================================================
module ofmap_buf_ctrl
   import ofmap_buf_ctrl_pkg::*;
#(
   parameter int NUM_BANK = SRAM_NUM_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [ADDR_W:0]            cfg_len,
   output logic                       busy,
   output logic                       done,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_BANK*DATA_W-1:0] in_data,
   input  logic [NUM_BANK-1:0]        in_strb,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_BANK*DATA_W-1:0] out_data,
   output logic                       sram_cen,
   output logic [NUM_BANK-1:0]        sram_wen,
   output logic [NUM_BANK*ADDR_W-1:0] sram_a,
   output logic [NUM_BANK*DATA_W-1:0] sram_d,
   input  logic [NUM_BANK*DATA_W-1:0] sram_q
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);

   logic [1:0]                 r_state;
   logic [1:0]                 w_state_nxt;
   logic [ADDR_W:0]            r_len;
   logic [ADDR_W:0]            r_wr_ptr;
   logic [ADDR_W:0]            r_rd_ptr;
   logic [ADDR_W:0]            r_pop_cnt;
   logic                       r_rd_pend_a;
   logic                       r_rd_pend_b;
   logic                       r_sram_cen;
   logic [NUM_BANK-1:0]        r_sram_wen;
   logic [NUM_BANK*ADDR_W-1:0] r_sram_a;
   logic [NUM_BANK*DATA_W-1:0] r_sram_d;

   logic                       w_in_ready;
   logic                       w_wr_fire;
   logic                       w_wr_last;
   logic                       w_pop;
   logic                       w_rd_last;
   logic                       w_rd_issue;
   logic                       w_start_ok;
   logic [1:0]                 w_occ;
   logic                       w_fifo_empty;

   assign w_start_ok = (r_state == S_IDLE) && start;
   assign w_wr_fire  = in_valid && w_in_ready;
   assign w_wr_last  = w_wr_fire && (r_wr_ptr == r_len - ONE);
   assign w_pop      = !w_fifo_empty && out_ready;
   assign w_rd_last  = w_pop && (r_pop_cnt == r_len - ONE);
   assign w_rd_issue = (r_state == S_READ) && (r_rd_ptr < r_len)
                       && rd_credit_ok(w_occ, r_rd_pend_a, r_rd_pend_b, w_pop);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = (cfg_len == '0) ? S_DONE : S_WRITE;
         S_WRITE: if (w_wr_last) w_state_nxt = S_READ;
         S_READ:  if (w_rd_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      w_in_ready = 1'b0;
      case (r_state)
         S_WRITE: begin busy = 1'b1; w_in_ready = 1'b1; end
         S_READ:  busy = 1'b1;
         S_DONE:  begin busy = 1'b1; done = 1'b1; end
         default: ;
      endcase
   end

   assign in_ready = w_in_ready;

   // SRAM port is idle (cen/wen high) unless a write or read is launched;
   // address and data keep their last values across idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_len       <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_pop_cnt   <= '0;
         r_rd_pend_a <= 1'b0;
         r_rd_pend_b <= 1'b0;
         r_sram_cen  <= 1'b1;
         r_sram_wen  <= '1;
         r_sram_a    <= '0;
         r_sram_d    <= '0;
      end else begin
         r_sram_cen <= 1'b1;
         r_sram_wen <= '1;
         if (w_start_ok) begin
            r_len     <= (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_pop_cnt <= '0;
         end
         if (w_wr_fire) begin
            r_sram_cen <= 1'b0;
            r_sram_wen <= ~in_strb;
            r_sram_a   <= {NUM_BANK{r_wr_ptr[ADDR_W-1:0]}};
            r_sram_d   <= in_data;
            r_wr_ptr   <= r_wr_ptr + ONE;
         end
         if (w_rd_issue) begin
            r_sram_cen <= 1'b0;
            r_sram_a   <= {NUM_BANK{r_rd_ptr[ADDR_W-1:0]}};
            r_rd_ptr   <= r_rd_ptr + ONE;
         end
         r_rd_pend_a <= w_rd_issue;
         r_rd_pend_b <= r_rd_pend_a;
         if (w_pop) r_pop_cnt <= r_pop_cnt + ONE;
      end
   end

   assign sram_cen = r_sram_cen;
   assign sram_wen = r_sram_wen;
   assign sram_a   = r_sram_a;
   assign sram_d   = r_sram_d;

   ofmap_out_fifo #(
      .WIDTH (NUM_BANK*DATA_W)
   ) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (r_rd_pend_b),
      .push_data (sram_q),
      .pop       (w_pop),
      .head      (out_data),
      .occ       (w_occ),
      .empty     (w_fifo_empty)
   );

   assign out_valid = !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_ofmap_buf_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ofmap_buf_ctrl : randomized frame tests against a frame-level model
// Rev 1.0
// ============================================================================
module tb_ofmap_buf_ctrl;
   import ofmap_buf_ctrl_pkg::*;

   localparam int NB  = SRAM_NUM_DEF;
   localparam int AW  = ADDR_W_DEF;
   localparam int DW  = DATA_W_DEF;
   localparam int DEP = DEPTH_DEF;
   localparam int W   = NB*DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW:0]   cfg_len = '0;
   logic          busy, done;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic [NB-1:0] in_strb = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
   logic          sram_cen;
   logic [NB-1:0] sram_wen;
   logic [NB*AW-1:0] sram_a;
   logic [W-1:0]  sram_d;
   logic [W-1:0]  sram_q;

   always #5 clk = ~clk;

   ofmap_buf_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
      .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_strb(in_strb),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d),
      .sram_q(sram_q)
   );

   // Behavioural bank array: per-bank byte write, registered read data.
   logic [DW-1:0] mem [NB][DEP];
   logic [W-1:0]  q_model = '0;
   assign sram_q = q_model;

   always @(posedge clk) begin
      if (sram_cen == 1'b0) begin
         for (int i = 0; i < NB; i++) begin
            if (sram_wen[i] == 1'b0)
               mem[i][sram_a[i*AW +: AW]] <= sram_d[i*DW +: DW];
            else if (&sram_wen)
               q_model[i*DW +: DW] <= mem[i][sram_a[i*AW +: AW]];
         end
      end
   end

   // Event counters observed at the bank port.
   int cyc = 0, done_cnt = 0, inrdy_cnt = 0, cen_low_cnt = 0, rd_port_cnt = 0;
   int wr_n = 0, a_rep_err = 0;
   logic [AW-1:0] wr_addr_log [1024];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (in_ready) inrdy_cnt <= inrdy_cnt + 1;
      if (sram_cen == 1'b0) begin
         cen_low_cnt <= cen_low_cnt + 1;
         if (sram_a !== {NB{sram_a[AW-1:0]}}) a_rep_err <= a_rep_err + 1;
         if (&sram_wen) rd_port_cnt <= rd_port_cnt + 1;
         else begin
            if (wr_n < 1024) wr_addr_log[wr_n] <= sram_a[AW-1:0];
            wr_n <= wr_n + 1;
         end
      end
   end

   // Frame-level reference: the bank contents as one word per address.
   logic [W-1:0]  exp_mem [DEP];
   logic [W-1:0]  tx_data [DEP];
   logic [NB-1:0] tx_strb [DEP];
   logic [W-1:0]  rx_q [$];

   int tests_run = 0, tests_failed = 0;
   int gap, timed_out, stall_err, max_outst;
   logic done_after, busy_after, done_after2, busy_after2;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] v;
      for (int i = 0; i < NB; i++) v[i*DW +: DW] = DW'($urandom);
      return v;
   endfunction

   task automatic fill_tx(input int len);
      for (int i = 0; i < len; i++) begin
         tx_data[i] = rand_word();
         tx_strb[i] = '1;
      end
   endtask

   task automatic do_frame(input int len, input int valid_pct, input int rdy_pct,
                           input bit poke_start);
      int b, guard, last_wr, rd_base, outst;
      logic [W-1:0] prev_data;
      bit prev_stall;
      rx_q.delete();
      gap = -1; timed_out = 0; stall_err = 0; max_outst = 0; last_wr = cyc;
      rd_base = rd_port_cnt;
      start = 1'b1; cfg_len = (AW+1)'(len);
      tick();
      start = 1'b0;
      b = 0; guard = 0;
      while (b < len && guard < 2000) begin
         in_valid = ($urandom_range(0, 99) < valid_pct);
         in_data  = tx_data[b];
         in_strb  = tx_strb[b];
         if (in_valid && in_ready) begin
            for (int i = 0; i < NB; i++)
               if (tx_strb[b][i]) exp_mem[b][i*DW +: DW] = tx_data[b][i*DW +: DW];
            last_wr = cyc;
            b++;
         end
         tick(); guard++;
      end
      in_valid = 1'b0;
      if (b < len) timed_out = 1;
      guard = 0; prev_stall = 0; prev_data = '0;
      while (rx_q.size() < len && guard < 4000) begin
         if (out_valid && gap < 0) gap = cyc - last_wr;
         if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
         outst = rd_port_cnt - rd_base - rx_q.size()
                 + ((sram_cen == 1'b0 && (&sram_wen)) ? 1 : 0);
         if (outst > max_outst) max_outst = outst;
         out_ready = ($urandom_range(0, 99) < rdy_pct);
         if (poke_start && guard == 1) begin
            start = 1'b1; cfg_len = (AW+1)'(5);
         end else start = 1'b0;
         if (out_valid && out_ready) rx_q.push_back(out_data);
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         tick(); guard++;
      end
      start = 1'b0; out_ready = 1'b0;
      if (rx_q.size() < len) timed_out = 1;
      done_after = done; busy_after = busy;
      tick();
      done_after2 = done; busy_after2 = busy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      tests_run++;
      if ({busy, done, in_ready, out_valid} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_flags got %b want 0000", {busy, done, in_ready, out_valid});
      end
      tests_run++;
      if (out_data !== '0 || sram_d !== '0 || sram_a !== '0) begin
         tests_failed++;
         $display("FAIL reset_data out_data=%h sram_a=%h sram_d=%h want 0", out_data, sram_a, sram_d);
      end
      tests_run++;
      if (sram_cen !== 1'b1 || sram_wen !== '1) begin
         tests_failed++;
         $display("FAIL reset_sram cen=%b wen=%b want 1/all ones", sram_cen, sram_wen);
      end
      rst = 1'b0;
      tick();
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_reset_busy got %b want 0", busy);
      end
   endtask

   task automatic test_basic();
      int base, errs, d0;
      fill_tx(4);
      base = wr_n; d0 = done_cnt;
      do_frame(4, 100, 100, 0);
      errs = 0;
      for (int i = 0; i < 4; i++) if (wr_addr_log[base+i] !== AW'(i)) errs++;
      tests_run++;
      if (wr_n - base != 4 || errs != 0) begin
         tests_failed++;
         $display("FAIL basic_wr_addr writes=%0d bad=%0d want 4/0", wr_n - base, errs);
      end
      errs = 0;
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== exp_mem[i]) errs++;
      tests_run++;
      if (rx_q.size() != 4 || errs != 0 || timed_out != 0) begin
         tests_failed++;
         $display("FAIL basic_data beats=%0d bad=%0d timeout=%0d want 4/0/0", rx_q.size(), errs, timed_out);
      end
      // READ is entered the cycle after the last write, then 3 cycles to out_valid.
      tests_run++;
      if (gap != 4) begin
         tests_failed++;
         $display("FAIL basic_latency got %0d want 4", gap);
      end
      tests_run++;
      if ({done_after, busy_after, done_after2, busy_after2} !== 4'b1100) begin
         tests_failed++;
         $display("FAIL basic_done_busy got %b want 1100", {done_after, busy_after, done_after2, busy_after2});
      end
      tests_run++;
      if (done_cnt - d0 != 1 || a_rep_err != 0) begin
         tests_failed++;
         $display("FAIL basic_done_count done=%0d addr_rep_err=%0d want 1/0", done_cnt - d0, a_rep_err);
      end
   endtask

   task automatic test_full_depth();
      int base, errs;
      fill_tx(DEP);
      base = wr_n;
      do_frame(DEP, 70, 100, 0);
      errs = 0;
      for (int i = 0; i < DEP; i++) if (wr_addr_log[base+i] !== AW'(i)) errs++;
      tests_run++;
      if (wr_n - base != DEP || errs != 0) begin
         tests_failed++;
         $display("FAIL full_wr_addr writes=%0d bad=%0d want %0d/0", wr_n - base, errs, DEP);
      end
      tests_run++;
      if (wr_addr_log[base+DEP-1] !== AW'(DEP-1)) begin
         tests_failed++;
         $display("FAIL full_last_addr got %0d want %0d", wr_addr_log[base+DEP-1], DEP-1);
      end
      errs = 0;
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== exp_mem[i]) errs++;
      tests_run++;
      if (rx_q.size() != DEP || errs != 0 || timed_out != 0) begin
         tests_failed++;
         $display("FAIL full_data beats=%0d bad=%0d timeout=%0d", rx_q.size(), errs, timed_out);
      end
   endtask

   task automatic test_strobe();
      logic [W-1:0]  old1, want1;
      logic [NB-1:0] pat;
      int errs;
      fill_tx(8);
      do_frame(8, 100, 100, 0);
      old1 = exp_mem[1];
      for (int i = 0; i < NB; i++) pat[i] = (i % 2 == 0);
      fill_tx(8);
      tx_strb[1] = pat;
      for (int i = 0; i < NB; i++)
         want1[i*DW +: DW] = pat[i] ? tx_data[1][i*DW +: DW] : old1[i*DW +: DW];
      do_frame(8, 100, 100, 0);
      tests_run++;
      if (rx_q.size() < 2 || rx_q[1] !== want1) begin
         tests_failed++;
         $display("FAIL strobe_beat1 got %h want %h", (rx_q.size() > 1) ? rx_q[1] : '0, want1);
      end
      errs = 0;
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== exp_mem[i]) errs++;
      tests_run++;
      if (rx_q.size() != 8 || errs != 0) begin
         tests_failed++;
         $display("FAIL strobe_frame beats=%0d bad=%0d want 8/0", rx_q.size(), errs);
      end
   endtask

   task automatic test_backpressure();
      int errs, d0;
      fill_tx(24);
      d0 = done_cnt;
      do_frame(24, 60, 50, 1);
      errs = 0;
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== exp_mem[i]) errs++;
      tests_run++;
      if (rx_q.size() != 24 || errs != 0 || timed_out != 0) begin
         tests_failed++;
         $display("FAIL bp_data beats=%0d bad=%0d timeout=%0d want 24/0/0", rx_q.size(), errs, timed_out);
      end
      tests_run++;
      if (stall_err != 0) begin
         tests_failed++;
         $display("FAIL bp_stable got %0d unstable stalls want 0", stall_err);
      end
      tests_run++;
      if (max_outst > 2) begin
         tests_failed++;
         $display("FAIL bp_outstanding got %0d want <=2", max_outst);
      end
      tests_run++;
      if (done_cnt - d0 != 1 || busy_after2 !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_start_ignored done=%0d busy=%b want 1/0", done_cnt - d0, busy_after2);
      end
   endtask

   task automatic test_zero_len();
      int cen0, rdy0;
      logic d1, b1, d2, b2;
      cen0 = cen_low_cnt; rdy0 = inrdy_cnt;
      start = 1'b1; cfg_len = '0;
      tick();
      start = 1'b0;
      d1 = done; b1 = busy;
      tick();
      d2 = done; b2 = busy;
      tick();
      tests_run++;
      if ({d1, b1, d2, b2} !== 4'b1100) begin
         tests_failed++;
         $display("FAIL zero_done got %b want 1100", {d1, b1, d2, b2});
      end
      tests_run++;
      if (cen_low_cnt != cen0 || inrdy_cnt != rdy0) begin
         tests_failed++;
         $display("FAIL zero_no_access cen_low=%0d in_ready=%0d want 0/0", cen_low_cnt - cen0, inrdy_cnt - rdy0);
      end
   endtask

   task automatic test_reset_midframe();
      int b, guard, errs;
      fill_tx(8);
      start = 1'b1; cfg_len = (AW+1)'(8);
      tick();
      start = 1'b0;
      b = 0; guard = 0;
      while (b < 2 && guard < 20) begin
         in_valid = 1'b1; in_data = tx_data[b]; in_strb = '1;
         if (in_ready) b++;
         tick(); guard++;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      tests_run++;
      if ({busy, done, in_ready, out_valid, sram_cen} !== 5'b00001 || sram_wen !== '1
          || sram_a !== '0 || sram_d !== '0 || out_data !== '0 || b != 2) begin
         tests_failed++;
         $display("FAIL midreset_outputs flags=%b wen=%b a=%h d=%h beats=%0d want 00001/ones/0/0/2",
                  {busy, done, in_ready, out_valid, sram_cen}, sram_wen, sram_a, sram_d, b);
      end
      rst = 1'b0;
      tick();
      fill_tx(2);
      do_frame(2, 100, 100, 0);
      errs = 0;
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== exp_mem[i]) errs++;
      tests_run++;
      if (rx_q.size() != 2 || errs != 0 || done_after !== 1'b1) begin
         tests_failed++;
         $display("FAIL midreset_next_frame beats=%0d bad=%0d done=%b want 2/0/1", rx_q.size(), errs, done_after);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_depth();
      test_strobe();
      test_backpressure();
      test_zero_len();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish (time %0t)", $time);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
